// File: rtl/alu_pkg.sv
// Shared definitions for the alu_pipe execute stage: ARM data-processing
// opcodes, opcode classification helpers and the multiply FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // TST/TEQ/CMP/CMN only update flags, no register writeback
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Ops whose carry comes from the shifter and whose V passes through
  function automatic logic is_logical_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result bus of the alu_pipe execute stage.
// slave: the ALU side; master: the issuing/writeback side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic             is_mul;
  logic             mul_acc;
  logic             set_flags;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             shifter_c;
  logic             o_n;
  logic             o_z;
  logic             o_c;
  logic             o_v;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             wr_en;
  logic             n;
  logic             z;
  logic             c;
  logic             v;
  logic             undef;

  modport slave (
    input  flush, in_valid, opcode, is_mul, mul_acc, set_flags,
           a, b, acc, shifter_c, o_n, o_z, o_c, o_v, out_ready,
    output in_ready, out_valid, out, wr_en, n, z, c, v, undef
  );

  modport master (
    output flush, in_valid, opcode, is_mul, mul_acc, set_flags,
           a, b, acc, shifter_c, o_n, o_z, o_c, o_v, out_ready,
    input  in_ready, out_valid, out, wr_en, n, z, c, v, undef
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: WIDTH/STEP_BITS cycles per product,
// low WIDTH bits kept. Product register is preloaded with the accumulate
// term so MLA costs nothing extra. o_done is asserted in the final
// iteration cycle together with the finished o_result.
// Only instantiated when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_abort,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned STEPS = WIDTH / STEP_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_sum;

  // Partial product of the multiplicand and the current STEP_BITS slice
  always_comb begin
    w_partial = '0;
    for (int unsigned j = 0; j < STEP_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  assign w_sum    = r_prod + w_partial;
  assign o_done   = r_busy && (r_cnt == CNT_W'(1));
  assign o_result = w_sum;

  // Iteration state: load on start, shift multiplicand/multiplier each step
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CNT_W'(STEPS);
      r_prod   <= i_acc;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_prod   <= w_sum;
      r_mcand  <= r_mcand << STEP_BITS;
      r_mplier <= r_mplier >> STEP_BITS;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU: ARM data-processing ops with N/Z/C/V generation,
// registered result with valid/ready handshake. Optional iterative MUL/MLA
// engine enabled by defining ALU_PIPE_MUL_EN; without it a multiply
// completes in one cycle flagged undef with no writeback.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MUL_STEP_BITS = 8
) (
  input logic      clk,
  input logic      rst,
  alu_pipe_if.slave bus
);

  logic             w_accept;
  logic             w_busy;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_res;
  logic             w_n, w_z, w_c, w_v;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_wr_en;
  logic             r_undef;
  logic             r_n, r_z, r_c, r_v;

  assign bus.in_ready = !w_busy && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

  // Adder operand selection; subtraction is a + ~b + carry-in
  always_comb begin
    w_op1 = bus.a;
    w_op2 = bus.b;
    w_cin = 1'b0;
    case (bus.opcode)
      OP_SUB, OP_CMP: begin w_op2 = ~bus.b; w_cin = 1'b1; end
      OP_RSB: begin w_op1 = bus.b; w_op2 = ~bus.a; w_cin = 1'b1; end
      OP_ADC: w_cin = bus.o_c;
      OP_SBC: begin w_op2 = ~bus.b; w_cin = bus.o_c; end
      OP_RSC: begin w_op1 = bus.b; w_op2 = ~bus.a; w_cin = bus.o_c; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_op1} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_op1[WIDTH-1] == w_op2[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_op1[WIDTH-1]);

  // Logical results
  always_comb begin
    w_logic = '0;
    case (bus.opcode)
      OP_AND, OP_TST: w_logic = bus.a & bus.b;
      OP_EOR, OP_TEQ: w_logic = bus.a ^ bus.b;
      OP_ORR:         w_logic = bus.a | bus.b;
      OP_MOV:         w_logic = bus.b;
      OP_BIC:         w_logic = bus.a & ~bus.b;
      OP_MVN:         w_logic = ~bus.b;
      default:        w_logic = '0;
    endcase
  end

  assign w_res = is_logical_op(bus.opcode) ? w_logic : w_sum[WIDTH-1:0];

  // Next flags for a data-processing op; S=0 passes current CPSR through
  always_comb begin
    w_n = bus.o_n;
    w_z = bus.o_z;
    w_c = bus.o_c;
    w_v = bus.o_v;
    if (bus.set_flags) begin
      w_n = w_res[WIDTH-1];
      w_z = (w_res == '0);
      w_c = is_logical_op(bus.opcode) ? bus.shifter_c : w_sum[WIDTH];
      w_v = is_logical_op(bus.opcode) ? bus.o_v : w_ovf;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_mul_init;
  logic             r_mul_s;
  logic             r_sv_n, r_sv_z, r_sv_c, r_sv_v;

  assign w_mul_init = bus.mul_acc ? bus.acc : '0;
  assign w_busy     = (r_state == S_MUL);

  alu_mul_iter #(
    .WIDTH     (WIDTH),
    .STEP_BITS (MUL_STEP_BITS)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_abort  (bus.flush),
    .i_start  (w_accept && bus.is_mul),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_acc    (w_mul_init),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  // Multiply FSM state register; rst and flush both abort to idle
  always_ff @(posedge clk) begin
    if (rst || bus.flush) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Multiply FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && bus.is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready)
                w_state_nxt = (w_accept && bus.is_mul) ? S_MUL : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // CPSR and S bit captured at multiply acceptance for the final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_s <= 1'b0;
      r_sv_n  <= 1'b0;
      r_sv_z  <= 1'b0;
      r_sv_c  <= 1'b0;
      r_sv_v  <= 1'b0;
    end else if (w_accept && bus.is_mul) begin
      r_mul_s <= bus.set_flags;
      r_sv_n  <= bus.o_n;
      r_sv_z  <= bus.o_z;
      r_sv_c  <= bus.o_c;
      r_sv_v  <= bus.o_v;
    end
  end
`else
  assign w_busy = 1'b0;
`endif

  // Result stage: load on accept or multiply completion, drop on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_wr_en     <= 1'b0;
      r_undef     <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      if (bus.is_mul) begin
`ifdef ALU_PIPE_MUL_EN
        r_out_valid <= 1'b0;
`else
        r_out_valid <= 1'b1;
        r_out       <= '0;
        r_wr_en     <= 1'b0;
        r_undef     <= 1'b1;
        r_n         <= bus.o_n;
        r_z         <= bus.o_z;
        r_c         <= bus.o_c;
        r_v         <= bus.o_v;
`endif
      end else begin
        r_out_valid <= 1'b1;
        r_out       <= w_res;
        r_wr_en     <= !is_test_op(bus.opcode);
        r_undef     <= 1'b0;
        r_n         <= w_n;
        r_z         <= w_z;
        r_c         <= w_c;
        r_v         <= w_v;
      end
`ifdef ALU_PIPE_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_out       <= w_mul_res;
      r_wr_en     <= 1'b1;
      r_undef     <= 1'b0;
      r_n         <= r_mul_s ? w_mul_res[WIDTH-1] : r_sv_n;
      r_z         <= r_mul_s ? (w_mul_res == '0) : r_sv_z;
      r_c         <= r_sv_c;
      r_v         <= r_sv_v;
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.wr_en     = r_wr_en;
  assign bus.undef     = r_undef;
  assign bus.n         = r_n;
  assign bus.z         = r_z;
  assign bus.c         = r_c;
  assign bus.v         = r_v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized ops
// against a plain-arithmetic reference model. Adapts to ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 32 / 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .MUL_STEP_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r,
                         input logic n, z, c, v, wr, ud);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".out"}, bus.out, r);
    chk({tag, ".nzcv"}, 32'({bus.n, bus.z, bus.c, bus.v}), 32'({n, z, c, v}));
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(wr));
    chk({tag, ".undef"}, 32'(bus.undef), 32'(ud));
  endtask

  // Reference: ARM semantics via wide signed/unsigned integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                input logic s, shc, fn, fz, fc, fv,
                                output logic [31:0] r, output logic n, z, c, v, wr);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint nb = fc ? 64'sd0 : 64'sd1;
    longint ures = 0, sres = 0;
    logic   cf = shc, arith = 1'b1;
    case (op)
      OP_ADD, OP_CMN: begin ures = ua + ub;      sres = sa + sb;      cf = ures > 64'sd4294967295; end
      OP_ADC:         begin ures = ua + ub + (1 - nb); sres = sa + sb + (1 - nb); cf = ures > 64'sd4294967295; end
      OP_SUB, OP_CMP: begin ures = ua - ub;      sres = sa - sb;      cf = ua >= ub; end
      OP_SBC:         begin ures = ua - ub - nb; sres = sa - sb - nb; cf = ua >= ub + nb; end
      OP_RSB:         begin ures = ub - ua;      sres = sb - sa;      cf = ub >= ua; end
      OP_RSC:         begin ures = ub - ua - nb; sres = sb - sa - nb; cf = ub >= ua + nb; end
      default: arith = 1'b0;
    endcase
    if (arith) r = ures[31:0];
    else case (op)
      OP_AND, OP_TST: r = a & b;
      OP_EOR, OP_TEQ: r = a ^ b;
      OP_ORR:         r = a | b;
      OP_MOV:         r = b;
      OP_BIC:         r = a & ~b;
      default:        r = ~b;
    endcase
    wr = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
    if (s) begin
      n = r[31];
      z = (r == 32'd0);
      c = cf;
      v = arith ? (sres > 64'sd2147483647 || sres < -64'sd2147483648) : fv;
    end else begin
      n = fn; z = fz; c = fc; v = fv;
    end
  endfunction

  task automatic set_ops(input logic [3:0] op, input logic [31:0] a, b,
                         input logic s, shc, fn, fz, fc, fv);
    bus.opcode = op; bus.is_mul = 1'b0; bus.mul_acc = 1'b0; bus.acc = '0;
    bus.a = a; bus.b = b; bus.set_flags = s; bus.shifter_c = shc;
    bus.o_n = fn; bus.o_z = fz; bus.o_c = fc; bus.o_v = fv;
  endtask

  task automatic dp(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                    input logic s, shc, fn, fz, fc, fv);
    logic [31:0] er;
    logic en, ez, ec, ev, ew;
    set_ops(op, a, b, s, shc, fn, fz, fc, fv);
    bus.out_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    model(op, a, b, s, shc, fn, fz, fc, fv, er, en, ez, ec, ev, ew);
    chk_out(tag, er, en, ez, ec, ev, ew, 1'b0);
  endtask

  task automatic mul_op(input string tag, input logic [31:0] a, b, acc,
                        input logic mla, s, fn, fz, fc, fv);
    longint unsigned p;
    logic [31:0] er;
    int cyc;
    bit early;
    set_ops(4'($urandom), a, b, s, 1'b0, fn, fz, fc, fv);
    bus.is_mul = 1'b1; bus.mul_acc = mla; bus.acc = acc;
    bus.out_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.is_mul = 1'b0;
    cyc = 0;
    early = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      if (bus.out_valid !== 1'b0) early = 1'b1;
      cyc++;
      tick();
    end
    chk({tag, ".busy_cycles"}, 32'(cyc), 32'(MUL_LAT));
    chk({tag, ".early_valid"}, 32'(early), 32'd0);
    p  = longint'({32'b0, a}) * longint'({32'b0, b}) + (mla ? longint'({32'b0, acc}) : 64'd0);
    er = p[31:0];
    chk_out(tag, er, s ? er[31] : fn, s ? (er == 0) : fz, fc, fv, 1'b1, 1'b0);
`else
    p  = 0;
    er = '0;
    chk_out(tag, er, fn, fz, fc, fv, 1'b0, 1'b1);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out"}, bus.out, 32'd0);
    chk({tag, ".nzcv_wr_ud"}, 32'({bus.n, bus.z, bus.c, bus.v, bus.wr_en, bus.undef}), 32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, sel;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_ops(OP_AND, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // Directed arithmetic/logical corner cases
    dp("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 0, 0, 0, 0, 0);
    chk("add_ovf.exact", {bus.out[31:0]}, 32'h8000_0000);
    chk("add_ovf.nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b1001);
    dp("cmp_eq", OP_CMP, 32'd5, 32'd5, 1, 0, 0, 0, 0, 0);
    chk("cmp_eq.nzcv", 32'({bus.n, bus.z, bus.c, bus.v, bus.wr_en}), 32'b01100);
    dp("sub_neg", OP_SUB, 32'd0, 32'd1, 1, 0, 0, 0, 1, 0);
    chk("sub_neg.exact", 32'({bus.out, bus.n, bus.c}), 32'({32'hFFFF_FFFF, 1'b1, 1'b0}));
    dp("sbc", OP_SBC, 32'd10, 32'd3, 1, 0, 0, 0, 0, 0);
    chk("sbc.exact", bus.out, 32'd6);
    dp("adc_wrap", OP_ADC, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 0, 1, 0);
    chk("adc_wrap.zc", 32'({bus.out == 0, bus.z, bus.c}), 32'b111);
    dp("mov_s", OP_MOV, 32'd0, 32'd0, 1, 1, 0, 0, 0, 1);
    chk("mov_s.nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b0111);
    dp("mov_nos", OP_MOV, 32'd0, 32'd0, 0, 1, 1, 0, 0, 1);
    chk("mov_nos.nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b1001);
    dp("rsc", OP_RSC, 32'd7, 32'd3, 1, 0, 0, 0, 0, 0);
    dp("teq", OP_TEQ, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 0, 0, 0, 1);

    // Multiply (or undef when the engine is absent)
    mul_op("mla", 32'd1000, 32'd3000, 32'd7, 1, 1, 0, 0, 1, 1);
`ifdef ALU_PIPE_MUL_EN
    chk("mla.exact", bus.out, 32'd3_000_007);
`else
    chk("mul_undef.exact", 32'({bus.undef, bus.wr_en}), 32'b10);
`endif
    mul_op("mul_s", 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 1, 0, 1, 0, 0);

    // Output stall with a competing op, then back-to-back replacement
    set_ops(OP_ADD, 32'd1, 32'd2, 0, 0, 1, 0, 1, 0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    set_ops(OP_SUB, 32'd9, 32'd4, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.out", bus.out, 32'd3);
      chk("stall.hold", 32'({bus.out_valid, bus.in_ready, bus.n, bus.z, bus.c, bus.v}), 32'b101010);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b.out", bus.out, 32'd5);
    chk("b2b.valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("drain.valid", 32'(bus.out_valid), 32'd0);

    // Flush drops an op presented in the same cycle
    set_ops(OP_ADD, 32'd4, 32'd4, 1, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_drop.valid", 32'(bus.out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    // Flush mid-multiply: result never appears, stage ready again
    set_ops(OP_AND, 32'd12, 32'd12, 1, 0, 0, 0, 0, 0);
    bus.is_mul = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.is_mul = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_mul.in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("flush_mul.valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    mul_op("mul_after_flush", 32'd123, 32'd456, 32'd0, 0, 1, 0, 0, 0, 0);

    // Reset mid-multiply
    bus.is_mul = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.is_mul = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_mul");
    repeat (MUL_LAT + 1) tick();
    chk("rst_mul.quiet", 32'(bus.out_valid), 32'd0);
`endif

    // Reset while a result is stalled
    dp("pre_rst", OP_ORR, 32'hF0, 32'h0F, 1, 0, 1, 1, 1, 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk_reset("rst_stall");

    // Randomized data-processing ops with edge-biased operands
    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: rb = ra;
        1: rb = 32'd0;
        2: rb = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      dp("rand_dp", 4'($urandom_range(0, 15)), ra, rb, 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      mul_op("rand_mul", $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
